// File: rtl/crd_intersect.sv
// ---------------------------------------------------------------------------
// CrdIntersect: two-lane coordinate intersection.
// Each lane presents a coordinate token with its reference token under one
// valid/ready handshake. Tokens are DATA_W+1 bits wide. Top bit 0 means data.
// Top bit 1 with payload DONE_CODE means "done". Any other top-bit-1 token is
// a stop marker whose level is the payload.
// Matching data coordinates are emitted with both references. Stop and done
// markers are aligned across the lanes and forwarded on all three outputs.
// All outputs come from registers.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   clk_en               freezes all state when low
//   flush                synchronous clear, same effect as reset
//   tile_en              block enable; when low, handshakes are blocked
//   crd_in_0, ref_in_0   lane 0 coordinate/reference (in_0_valid/in_0_ready)
//   crd_in_1, ref_in_1   lane 1 coordinate/reference (in_1_valid/in_1_ready)
//   crd_out, ref_out_0,  registered output triple (out_valid/out_ready)
//   ref_out_1
//   err                  only with CRD_INTERSECT_ERR_EN defined: sticky flag,
//                        set when two stop markers with different levels meet
//
// Build option: define CRD_INTERSECT_ERR_EN to add the err port.
// ---------------------------------------------------------------------------
module crd_intersect #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] DONE_CODE = DATA_W'(16'h0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            flush,
  input  logic            tile_en,
  input  logic [DATA_W:0] crd_in_0,
  input  logic [DATA_W:0] ref_in_0,
  input  logic            in_0_valid,
  output logic            in_0_ready,
  input  logic [DATA_W:0] crd_in_1,
  input  logic [DATA_W:0] ref_in_1,
  input  logic            in_1_valid,
  output logic            in_1_ready,
  output logic [DATA_W:0] crd_out,
  output logic [DATA_W:0] ref_out_0,
  output logic [DATA_W:0] ref_out_1,
  output logic            out_valid,
  input  logic            out_ready
`ifdef CRD_INTERSECT_ERR_EN
  ,
  output logic            err
`endif
);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_valid;
  logic [DATA_W:0] r_crd;
  logic [DATA_W:0] r_ref0;
  logic [DATA_W:0] r_ref1;
  logic            r_err;

  logic            w_aData, w_aDone, w_aStop;
  logic            w_bData, w_bDone, w_bStop;
  logic            w_emit, w_pop0, w_pop1, w_mismatch;
  logic [DATA_W:0] w_emitCrd, w_emitRef0, w_emitRef1;
  logic            w_decide, w_space, w_fire, w_outValid, w_outXfer;

  assign w_aData = ~crd_in_0[DATA_W];
  assign w_aDone =  crd_in_0[DATA_W] & (crd_in_0[DATA_W-1:0] == DONE_CODE);
  assign w_aStop =  crd_in_0[DATA_W] & ~w_aDone;
  assign w_bData = ~crd_in_1[DATA_W];
  assign w_bDone =  crd_in_1[DATA_W] & (crd_in_1[DATA_W-1:0] == DONE_CODE);
  assign w_bStop =  crd_in_1[DATA_W] & ~w_bDone;

  // out_valid is held low while the block is frozen or disabled.
  // A transfer can therefore never be seen by the consumer while our state
  // cannot advance.
  assign w_outValid = r_valid & tile_en & clk_en;
  assign w_outXfer  = w_outValid & out_ready;
  assign w_space    = ~w_outValid | out_ready;
  assign w_decide   = clk_en & tile_en & (r_state == ST_RUN) & in_0_valid & in_1_valid;
  // Emitting decisions wait for output space. Pure pops never wait.
  assign w_fire     = w_decide & w_emit & w_space;

  // Decision table on the two lane heads, plus the next-state logic.
  always_comb begin
    w_emit      = 1'b0;
    w_pop0      = 1'b0;
    w_pop1      = 1'b0;
    w_mismatch  = 1'b0;
    w_emitCrd   = '0;
    w_emitRef0  = '0;
    w_emitRef1  = '0;
    w_nextState = r_state;

    if (w_aData && w_bData) begin
      if (crd_in_0[DATA_W-1:0] == crd_in_1[DATA_W-1:0]) begin
        w_emit     = 1'b1;
        w_pop0     = 1'b1;
        w_pop1     = 1'b1;
        w_emitCrd  = crd_in_0;
        w_emitRef0 = ref_in_0;
        w_emitRef1 = ref_in_1;
      end else if (crd_in_0[DATA_W-1:0] < crd_in_1[DATA_W-1:0]) begin
        w_pop0 = 1'b1;
      end else begin
        w_pop1 = 1'b1;
      end
    end else if (w_aData) begin
      // Lane 0 data cannot match a marker on lane 1, so drop it.
      w_pop0 = 1'b1;
    end else if (w_bData) begin
      w_pop1 = 1'b1;
    end else if (w_aStop && w_bStop) begin
      // Differing levels still emit lane 0's level, so the stream stays aligned.
      w_emit     = 1'b1;
      w_pop0     = 1'b1;
      w_pop1     = 1'b1;
      w_mismatch = (crd_in_0 != crd_in_1);
      w_emitCrd  = crd_in_0;
      w_emitRef0 = crd_in_0;
      w_emitRef1 = crd_in_0;
    end else if (w_aDone && w_bDone) begin
      w_emit     = 1'b1;
      w_pop0     = 1'b1;
      w_pop1     = 1'b1;
      w_emitCrd  = crd_in_0;
      w_emitRef0 = crd_in_0;
      w_emitRef1 = crd_in_0;
    end else if (w_aStop) begin
      // Stop on lane 0 against done on lane 1: lane 0 catches up.
      w_pop0 = 1'b1;
    end else begin
      w_pop1 = 1'b1;
    end

    case (r_state)
      ST_START: if (tile_en) w_nextState = ST_RUN;
      ST_RUN:   if (w_fire && w_aDone && w_bDone) w_nextState = ST_DONE;
      ST_DONE:  if (w_outXfer) w_nextState = ST_START;
      default:  w_nextState = ST_START;
    endcase
  end

  assign in_0_ready = w_decide & w_pop0 & (~w_emit | w_space);
  assign in_1_ready = w_decide & w_pop1 & (~w_emit | w_space);
  assign out_valid  = w_outValid;
  assign crd_out    = r_crd;
  assign ref_out_0  = r_ref0;
  assign ref_out_1  = r_ref1;

`ifdef CRD_INTERSECT_ERR_EN
  assign err = r_err;
`endif

  // State register and output register.
  // Reset and flush override clk_en, and they discard any pending output.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= ST_START;
      r_valid <= 1'b0;
      r_crd   <= '0;
      r_ref0  <= '0;
      r_ref1  <= '0;
      r_err   <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_nextState;
      if (w_fire) begin
        r_valid <= 1'b1;
        r_crd   <= w_emitCrd;
        r_ref0  <= w_emitRef0;
        r_ref1  <= w_emitRef1;
      end else if (w_outXfer) begin
        r_valid <= 1'b0;
      end
      if (w_fire && w_mismatch) r_err <= 1'b1;
    end
  end

`ifndef CRD_INTERSECT_ERR_EN
  logic w_unusedErr;
  assign w_unusedErr = r_err;
`endif

endmodule
